// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave controller.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;

  localparam logic [I2C_ADDR_W-1:0] I2C_DEFAULT_SLAVE_ADDR = 7'h50;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// One I2C line: 2-flop synchronizer, optional glitch filter
// (I2C_GLITCH_FILTER_EN), and registered edge detect.
// Event latency is 3 clk, or 3+FILTER_LEN clk with the filter.
module i2c_line_sync #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_rise;
  logic r_fall;
  logic w_cur;

  // Synchronize the asynchronous line; reset to the idle-bus level (high).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // Accept a new level only after it differs for FILTER_LEN consecutive clks.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (r_s2 != r_filt) begin
      if (r_cnt == CNT_LAST) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_cur = r_filt;
`else
  assign w_cur = r_s2;
`endif

  // Edge detect; the level output is aligned with the edge pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_cur;
      r_rise <= w_cur & ~r_prev;
      r_fall <= ~w_cur & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_controller.sv
// I2C slave front-end, 7-bit fixed address, write (rx) and read (tx).
// Optional input glitch filter enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_slave_controller
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = I2C_DEFAULT_SLAVE_ADDR,
  parameter int unsigned           FILTER_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [I2C_BYTE_W-1:0] data_out,
  input  logic [I2C_BYTE_W-1:0] data_in,
  output logic                  done,
  output logic                  ack
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_line  (scl),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_line  (sda),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  i2c_state_t            r_state, w_state_nxt;
  logic [I2C_BYTE_W-1:0] r_shift, w_shift_nxt;
  logic [2:0]            r_cnt, w_cnt_nxt;
  logic                  r_rw, w_rw_nxt;
  logic                  r_sda_oe, w_sda_oe_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_done, w_done_nxt;
  logic [I2C_BYTE_W-1:0] r_data_out, w_data_out_nxt;

  logic                  w_start, w_stop, w_last;
  logic [I2C_BYTE_W-1:0] w_byte;

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;
  assign w_last  = (r_cnt == 3'd7);
  assign w_byte  = {r_shift[I2C_BYTE_W-2:0], w_sda_lvl};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; START/STOP take priority over any scl edge.
  // In the ACK states r_ack tells the first (drive) fall from the second (release) fall.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ADDR;
    end else if (w_stop) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        ADDR:     if (w_scl_rise && w_last)
                    w_state_nxt = (w_byte[I2C_BYTE_W-1:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK: if (w_scl_fall && r_ack) w_state_nxt = r_rw ? TX : RX;
        RX:       if (w_scl_rise && w_last) w_state_nxt = RX_ACK;
        RX_ACK:   if (w_scl_fall && r_ack) w_state_nxt = RX;
        TX:       if (w_scl_fall && (r_cnt == 3'd0)) w_state_nxt = TX_ACK;
        TX_ACK: begin
          if (w_scl_rise && w_sda_lvl) w_state_nxt = IDLE;
          else if (w_scl_fall)         w_state_nxt = TX;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output next values.
  // In TX_ACK the next byte is loaded on the ACK rise and its MSB driven on the following fall.
  always_comb begin
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_ack_nxt      = r_ack;
    w_done_nxt     = 1'b0;
    w_data_out_nxt = r_data_out;
    if (w_start || w_stop) begin
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
      w_ack_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt + 3'd1;
          if (w_last && (w_byte[I2C_BYTE_W-1:1] == SLAVE_ADDR)) w_rw_nxt = w_byte[0];
        end
        ADDR_ACK, RX_ACK: if (w_scl_fall) begin
          if (!r_ack) begin
            w_sda_oe_nxt = 1'b1;
            w_ack_nxt    = 1'b1;
          end else begin
            w_sda_oe_nxt = 1'b0;
            w_ack_nxt    = 1'b0;
            if ((r_state == ADDR_ACK) && r_rw) begin
              w_shift_nxt  = data_in;
              w_sda_oe_nxt = ~data_in[I2C_BYTE_W-1];
            end
          end
        end
        RX: if (w_scl_rise) begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_cnt + 3'd1;
          if (w_last) begin
            w_data_out_nxt = w_byte;
            w_done_nxt     = 1'b1;
          end
        end
        TX: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[I2C_BYTE_W-2:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[I2C_BYTE_W-2];
            end
          end
        end
        TX_ACK: begin
          if (w_scl_rise) begin
            w_done_nxt = 1'b1;
            if (!w_sda_lvl) w_shift_nxt = data_in;
          end else if (w_scl_fall) begin
            w_sda_oe_nxt = ~r_shift[I2C_BYTE_W-1];
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_ack      <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_ack      <= w_ack_nxt;
      r_done     <= w_done_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign data_out = r_data_out;
  assign done     = r_done;
  assign ack      = r_ack;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Bench for i2c_slave_controller: bit-level I2C master, transaction-level expectations.
module tb_i2c_slave_controller;
  import i2c_pkg::*;

  localparam int unsigned Q = 10;  // clk cycles per quarter scl period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] data_in = '0;
  wire        sda;
  logic [7:0] data_out;
  logic       done;
  logic       ack;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_controller #(.SLAVE_ADDR(7'h50), .FILTER_LEN(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .data_out (data_out),
    .data_in  (data_in),
    .done     (done),
    .ack      (ack)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_done = 0;
  int unsigned n_both = 0;
  int unsigned n_slave_low = 0;

  always @(posedge clk) begin
    if (done) n_done <= n_done + 1;
    if (done && ack) n_both <= n_both + 1;
    if (!m_sda_low && sda == 1'b0) n_slave_low <= n_slave_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b0;       wait_clk(Q);
  endtask

  task automatic i2c_stop();
    scl = 1'b0; m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b1;                   wait_clk(Q);
    m_sda_low = 1'b0;             wait_clk(Q);
  endtask

  // One scl clock; b=1 releases sda. Returns bus sda and the ack flag mid-high.
  task automatic clk_bit(input logic b, output logic s, output logic a);
    m_sda_low = ~b; wait_clk(Q);
    scl = 1'b1;     wait_clk(Q);
    s = sda; a = ack;
    wait_clk(Q);
    scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic s, output logic a);
    logic ds, da;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], ds, da);
    clk_bit(1'b1, s, a);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic [7:0] next_data, input logic m_ack);
    logic s, a;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s, a);
      b[i] = s;
    end
    data_in = next_data;
    clk_bit(~m_ack, s, a);
  endtask

  logic [7:0]  exp_data_out = '0;
  logic [7:0]  got_b;
  logic        s, a;
  int unsigned d0, l0, nb;
  logic [7:0]  bytes[$];

  initial begin
    // reset
    wait_clk(5);
    check("rst_data_out", data_out, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_sda", sda, 1'b1);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    wait_clk(5);

    // directed write 0x50+W, 0xA5
    d0 = n_done;
    i2c_start();
    write_byte(8'hA0, s, a);
    check("wr_addr_sda", s, 1'b0);
    check("wr_addr_ack", a, 1'b1);
    write_byte(8'hA5, s, a);
    check("wr_data_sda", s, 1'b0);
    check("wr_data_ack", a, 1'b1);
    i2c_stop();
    exp_data_out = 8'hA5;
    check("wr_data_out", data_out, exp_data_out);
    check("wr_done_cnt", n_done - d0, 1);
    check("wr_idle", 32'(dut.r_state), 32'(IDLE));
    check("wr_ack_after_stop", ack, 1'b0);

    // randomized writes
    for (int t = 0; t < 4; t++) begin
      nb = $urandom_range(1, 4);
      d0 = n_done;
      i2c_start();
      write_byte(8'hA0, s, a);
      check("rwr_addr_ack", a, 1'b1);
      for (int k = 0; k < int'(nb); k++) begin
        got_b = 8'($urandom);
        write_byte(got_b, s, a);
        exp_data_out = got_b;
        check("rwr_byte_sda", s, 1'b0);
      end
      i2c_stop();
      check("rwr_data_out", data_out, exp_data_out);
      check("rwr_done_cnt", n_done - d0, nb);
    end

    // address mismatch: directed then random
    for (int t = 0; t < 3; t++) begin
      logic [6:0] ad;
      if (t == 0) begin
        ad = 7'h51;
        got_b = 8'hA2;
      end else begin
        ad = 7'($urandom_range(0, 127));
        if (ad == 7'h50) ad = 7'h2B;
        got_b = {ad, 1'($urandom)};
      end
      d0 = n_done;
      l0 = n_slave_low;
      i2c_start();
      write_byte(got_b, s, a);
      check("nm_addr_sda", s, 1'b1);
      check("nm_addr_ack", a, 1'b0);
      write_byte(8'hA5, s, a);
      check("nm_data_ack", a, 1'b0);
      i2c_stop();
      check("nm_slave_low", n_slave_low - l0, 0);
      check("nm_done_cnt", n_done - d0, 0);
      check("nm_data_out", data_out, exp_data_out);
    end

    // directed read 0x3C (ACK) then 0xC3 (NACK)
    d0 = n_done;
    data_in = 8'h3C;
    i2c_start();
    write_byte(8'hA1, s, a);
    check("rd_addr_ack", a, 1'b1);
    read_byte(got_b, 8'hC3, 1'b1);
    check("rd_byte0", got_b, 8'h3C);
    read_byte(got_b, 8'h00, 1'b0);
    check("rd_byte1", got_b, 8'hC3);
    check("rd_done_cnt", n_done - d0, 2);
    check("rd_idle_after_nack", 32'(dut.r_state), 32'(IDLE));
    i2c_stop();

    // randomized reads
    for (int t = 0; t < 3; t++) begin
      nb = $urandom_range(1, 4);
      bytes.delete();
      for (int k = 0; k <= int'(nb); k++) bytes.push_back(8'($urandom));
      d0 = n_done;
      data_in = bytes[0];
      i2c_start();
      write_byte(8'hA1, s, a);
      check("rrd_addr_ack", a, 1'b1);
      for (int k = 0; k < int'(nb); k++) begin
        read_byte(got_b, bytes[k+1], (k != int'(nb) - 1));
        check("rrd_byte", got_b, bytes[k]);
      end
      check("rrd_done_cnt", n_done - d0, nb);
      i2c_stop();
    end

    // repeated START mid-byte discards the partial byte
    d0 = n_done;
    i2c_start();
    write_byte(8'hA0, s, a);
    for (int k = 0; k < 4; k++) clk_bit(1'($urandom), s, a);
    i2c_start();
    write_byte(8'hA0, s, a);
    check("rs_addr_ack", a, 1'b1);
    write_byte(8'h5A, s, a);
    i2c_stop();
    exp_data_out = 8'h5A;
    check("rs_data_out", data_out, exp_data_out);
    check("rs_done_cnt", n_done - d0, 1);

    // reset for one clk during a received data byte
    i2c_start();
    write_byte(8'hA0, s, a);
    for (int k = 0; k < 4; k++) clk_bit(1'($urandom), s, a);
    m_sda_low = 1'b0;
    wait_clk(Q);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    exp_data_out = 8'h00;
    check("mr_data_out", data_out, exp_data_out);
    check("mr_done", done, 1'b0);
    check("mr_ack", ack, 1'b0);
    check("mr_sda", sda, 1'b1);
    check("mr_state", 32'(dut.r_state), 32'(IDLE));
    wait_clk(Q);
    d0 = n_done;
    i2c_start();
    write_byte(8'hA0, s, a);
    check("mr_post_addr_ack", a, 1'b1);
    for (int k = 0; k < 2; k++) begin
      got_b = 8'($urandom);
      write_byte(got_b, s, a);
      exp_data_out = got_b;
    end
    i2c_stop();
    check("mr_post_data_out", data_out, exp_data_out);
    check("mr_post_done_cnt", n_done - d0, 2);

`ifdef I2C_GLITCH_FILTER_EN
    // 2-clk low spike on sda with scl high must not register as START
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(2);
    m_sda_low = 1'b0;
    wait_clk(30);
    check("gf_state", 32'(dut.r_state), 32'(IDLE));
    check("gf_data_out", data_out, exp_data_out);
`endif

    check("done_ack_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
